// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: formats a byte into a start/data/(parity)/stop frame and
// paces load/shift strobes for a downstream LSB-first parallel-to-serial shift register.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    localparam int unsigned FRAME_BITS  = 10 + PARITY_EN
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic                  load_enable,
    output logic                  shift_enable,
    output logic [FRAME_BITS-1:0] parallel_out,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       idx_q;
    logic [7:0]       data_q;
    logic             ready_q;
    logic             busy_q;
    logic             load_q;
    logic             shift_q;
    logic             done_q;
    logic [FRAME_BITS-1:0] frame;

    // Strobes are registered one cycle early (at CNT_PRE) so they are high exactly
    // while the counter sits at CNT_LAST.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= 8'hFF;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        data_q  <= tx_data;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        load_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_PRE) begin
                            shift_q <= (idx_q != IDX_LAST);
                            done_q  <= (idx_q == IDX_LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        frame      = '1;
        frame[0]   = 1'b0;
        frame[8:1] = data_q;
        if (PARITY_EN != 0) begin
            frame[9] = (^data_q) ^ (PARITY_ODD != 0);
        end
    end

    assign parallel_out = busy_q ? frame : '1;
    assign tx_ready     = ready_q;
    assign tx_busy      = busy_q;
    assign load_enable  = load_q;
    assign shift_enable = shift_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: four parameterisations, expected frames queued by
// the stimulus and checked by a negedge monitor with an attached shift-register model.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        tv  [4];
    logic [7:0]  td  [4];
    logic        rdy [4];
    logic        bsy [4];
    logic        le  [4];
    logic        se  [4];
    logic        fd  [4];
    logic [10:0] po  [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned CPB = (g == 3) ? 2 : 16;
        localparam int unsigned PE  = (g == 1 || g == 2) ? 1 : 0;
        localparam int unsigned PO  = (g == 2) ? 1 : 0;
        localparam int unsigned FB  = 10 + PE;
        logic [FB-1:0] po_w;
        uart_tx_ctrl #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO)
        ) u_dut (
            .clk         (clk),
            .n_rst       (n_rst),
            .tx_valid    (tv[g]),
            .tx_data     (td[g]),
            .tx_ready    (rdy[g]),
            .load_enable (le[g]),
            .shift_enable(se[g]),
            .parallel_out(po_w),
            .tx_busy     (bsy[g]),
            .frame_done  (fd[g])
        );
        assign po[g] = 11'(po_w);
    end

    typedef struct {
        int          inst;
        logic [10:0] po;
        int          lcyc;
        int          fb;
        int          cpb;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    bit          active = 1'b0;
    int          shifts;
    logic [10:0] sr;
    bit          viol_rb, viol_po;
    int          frames_seen = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h expected=%0h (t=%0t cyc=%0d)", nm, inst, act, exp, $time, cyc);
        end
    endtask

    task automatic push(input int i, input logic [10:0] p, input int l, input int fb, input int cpb);
        exp_t e;
        e.inst = i; e.po = p; e.lcyc = l; e.fb = fb; e.cpb = cpb;
        sbq.push_back(e);
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic [10:0] p,
                        input int fb, input int cpb, output int l);
        @(negedge clk);
        tv[i] = 1'b1;
        td[i] = d;
        l = cyc + 1;
        push(i, p, l, fb, cpb);
        @(negedge clk);
        tv[i] = 1'b0;
        td[i] = 8'h3C;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int n = 0; n < budget && frames_seen < target; n++) @(negedge clk);
        check("frames_completed", -1, frames_seen, target);
    endtask

    // Monitor: loads pop the scoreboard; shifts and done are checked against the popped frame.
    always @(negedge clk) begin
        if (!n_rst) active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (le[i]) begin
                check("le_se_exclusive", i, se[i], 0);
                check("load_while_idle", i, active, 0);
                check("sb_nonempty", i, sbq.size() > 0, 1);
                if (!active && sbq.size() > 0) begin
                    cur = sbq.pop_front();
                    check("load_inst", i, i, cur.inst);
                    check("load_cycle", i, cyc, cur.lcyc);
                    check("load_frame", i, po[i], cur.po);
                    check("load_ready_busy", i, {rdy[i], bsy[i]}, 2'b01);
                    active  = 1'b1;
                    shifts  = 0;
                    sr      = po[i];
                    viol_rb = 1'b0;
                    viol_po = 1'b0;
                    check("serial_bit0", i, sr[0], cur.po[0]);
                end
            end else if (active && i == cur.inst) begin
                if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1) viol_rb = 1'b1;
                if (po[i] !== cur.po) viol_po = 1'b1;
                if (se[i]) begin
                    shifts++;
                    check("shift_cycle", i, cyc, cur.lcyc + shifts * cur.cpb);
                    if (shifts < 11) begin
                        sr = {1'b1, sr[10:1]};
                        check("serial_bit", i, sr[0], cur.po[shifts]);
                    end
                end
                if (fd[i]) begin
                    check("done_cycle", i, cyc, cur.lcyc + cur.fb * cur.cpb);
                    check("shift_count", i, shifts, cur.fb - 1);
                    check("ready_low_busy_high", i, viol_rb, 0);
                    check("frame_stable", i, viol_po, 0);
                    active = 1'b0;
                    frames_seen++;
                end
            end else if (se[i] || fd[i]) begin
                check("stray_strobe", i, {se[i], fd[i]}, 0);
            end
        end
    end

    initial begin
        int h;
        int l;
        n_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tv[i] = 1'b0;
            td[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_ready_busy", i, {rdy[i], bsy[i]}, 2'b10);
            check("rst_strobes", i, {le[i], se[i], fd[i]}, 3'b000);
            check("rst_frame_ones", i, po[i], (i == 1 || i == 2) ? 11'h7FF : 11'h3FF);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("idle_ready_busy", i, {rdy[i], bsy[i]}, 2'b10);
            check("idle_frame_ones", i, po[i], (i == 1 || i == 2) ? 11'h7FF : 11'h3FF);
        end

        send(0, 8'hA5, 11'b0_1_10100101_0, 10, 16, l);
        wait_frames(1, 200);
        send(1, 8'h07, 11'b1_1_00000111_0, 11, 16, l);
        wait_frames(2, 220);
        send(1, 8'hFF, 11'b1_0_11111111_0, 11, 16, l);
        wait_frames(3, 220);
        send(2, 8'h07, 11'b1_0_00000111_0, 11, 16, l);
        wait_frames(4, 220);
        send(3, 8'h3C, 11'b0_1_00111100_0, 10, 2, l);
        wait_frames(5, 40);

        // Held tx_valid: data changes mid-frame must only appear in the following frame.
        @(negedge clk);
        h = cyc + 1;
        tv[0] = 1'b1;
        td[0] = 8'h00;
        push(0, 11'b0_1_00000000_0, h, 10, 16);
        push(0, 11'b0_1_11111111_0, h + 162, 10, 16);
        push(0, 11'b0_1_00111100_0, h + 324, 10, 16);
        while (cyc < h + 50) @(negedge clk);
        td[0] = 8'hFF;
        while (cyc < h + 212) @(negedge clk);
        td[0] = 8'h3C;
        while (cyc < h + 324) @(negedge clk);
        tv[0] = 1'b0;
        wait_frames(8, 600);

        // Reset while bit index is 4, then a fresh frame.
        send(0, 8'h96, 11'b0_1_10010110_0, 10, 16, l);
        while (cyc < l + 4 * 16 + 8) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("abort_ready_busy", 0, {rdy[0], bsy[0]}, 2'b10);
        check("abort_strobes", 0, {le[0], se[0], fd[0]}, 3'b000);
        check("abort_frame_ones", 0, po[0], 11'h3FF);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 0, frames_seen, 8);
        send(0, 8'h5A, 11'b0_1_01011010_0, 10, 16, l);
        wait_frames(9, 200);

        check("sb_empty", -1, sbq.size(), 0);
        check("no_frame_open", -1, active, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
